// File: rtl/dnn_input_pkg.sv
// Shared constants, FSM encodings and bit-index helpers for the DNN input path.
package dnn_input_pkg;

  localparam int unsigned IMG_DIM   = 32;
  localparam int unsigned IMG_BITS  = 1024;
  localparam int unsigned COORD_W   = 5;
  localparam int unsigned BEAT_W    = 10;
  localparam int unsigned SHIFT_W   = 6;
  localparam int unsigned SRC_W     = 7;
  localparam int unsigned PIX_W_DEF = 8;
  localparam logic [7:0]  PIX_ONE_DEF = 8'd127;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] CALC   = 2'd2;
  localparam logic [1:0] STREAM = 2'd3;

  // Bitmap addressing: column-major, bit = x*32 + y.
  function automatic logic [BEAT_W-1:0] bit_index(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    return {x, y};
  endfunction

  function automatic logic [COORD_W-1:0] lowest_set(input logic [IMG_DIM-1:0] w);
    logic [COORD_W-1:0] r;
    r = '0;
    for (int i = IMG_DIM - 1; i >= 0; i--) begin
      if (w[i]) r = COORD_W'(i);
    end
    return r;
  endfunction

  function automatic logic [COORD_W-1:0] highest_set(input logic [IMG_DIM-1:0] w);
    logic [COORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < IMG_DIM; i++) begin
      if (w[i]) r = COORD_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/image_streamer_if.sv
// Pixel stream handshake between image_streamer (master) and the DNN input layer.
interface image_streamer_if
  import dnn_input_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
);
  logic [PIX_W-1:0] oPixel;
  logic             oValid;
  logic             iReady;
  logic             oLast;

  modport master (output oPixel, output oValid, output oLast, input iReady);
  modport slave  (input oPixel, input oValid, input oLast, output iReady);
endinterface

// File: rtl/bbox_scanner.sv
// Accumulates the bounding box of set bits as columns are stepped in ascending x order.
module bbox_scanner
  import dnn_input_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               step_i,
  input  logic [IMG_DIM-1:0] col_i,
  input  logic [COORD_W-1:0] idx_i,
  output logic [COORD_W-1:0] min_x_o,
  output logic [COORD_W-1:0] max_x_o,
  output logic [COORD_W-1:0] min_y_o,
  output logic [COORD_W-1:0] max_y_o,
  output logic               empty_o
);

  logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [COORD_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic               any_q, any_d;
  logic [COORD_W-1:0] lo_y, hi_y;

  assign lo_y = lowest_set(col_i);
  assign hi_y = highest_set(col_i);

  // First nonzero column seeds the box; later ones widen it.
  always_comb begin
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    any_d   = any_q;
    if (clear_i) begin
      min_x_d = '0;
      max_x_d = '0;
      min_y_d = '0;
      max_y_d = '0;
      any_d   = 1'b0;
    end else if (step_i && (col_i != '0)) begin
      any_d   = 1'b1;
      max_x_d = idx_i;
      if (!any_q) begin
        min_x_d = idx_i;
        min_y_d = lo_y;
        max_y_d = hi_y;
      end else begin
        if (lo_y < min_y_q) min_y_d = lo_y;
        if (hi_y > max_y_q) max_y_d = hi_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
      any_q   <= 1'b0;
    end else begin
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      any_q   <= any_d;
    end
  end

  assign min_x_o = min_x_q;
  assign max_x_o = max_x_q;
  assign min_y_o = min_y_q;
  assign max_y_o = max_y_q;
  assign empty_o = !any_q;

endmodule

// File: rtl/image_streamer.sv
// Snapshots the 32x32 canvas and streams it as 1024 pixels; optional digit recentring
// is compiled in with the CENTER_EN macro.
module image_streamer
  import dnn_input_pkg::*;
#(
  parameter int unsigned      PIX_W   = PIX_W_DEF,
  parameter logic [PIX_W-1:0] PIX_ONE = PIX_W'(PIX_ONE_DEF)
) (
  input  logic                      iBusClk,
  input  logic                      iRstN,
  input  logic                      iStart,
  input  logic [IMG_BITS-1:0]       iImage,
  image_streamer_if.master          m_if,
  output logic                      oBusy,
  output logic                      oDone,
  output logic signed [SHIFT_W-1:0] oShiftX,
  output logic signed [SHIFT_W-1:0] oShiftY
);

  logic [1:0]                state_q, state_d;
  logic [IMG_BITS-1:0]       snap_q, snap_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [PIX_W-1:0]          pix_q, pix_d;
  logic                      valid_q, valid_d;
  logic                      last_q, last_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic signed [SHIFT_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic                      start_go;

  // A start coinciding with the done pulse is dropped.
  assign start_go = (state_q == IDLE) && iStart && !done_q;

  // Pixel for output beat n after undoing the recentre shift.
  function automatic logic pix_bit(input logic [IMG_BITS-1:0]       img,
                                   input logic [BEAT_W-1:0]         beat,
                                   input logic signed [SHIFT_W-1:0] sx,
                                   input logic signed [SHIFT_W-1:0] sy);
    logic signed [SRC_W-1:0] src_x, src_y;
    src_x = $signed({2'b00, beat[COORD_W-1:0]}) - $signed({sx[SHIFT_W-1], sx});
    src_y = $signed({2'b00, beat[BEAT_W-1:COORD_W]}) - $signed({sy[SHIFT_W-1], sy});
    if ((src_x[SRC_W-1:COORD_W] != 2'b00) || (src_y[SRC_W-1:COORD_W] != 2'b00)) return 1'b0;
    return img[bit_index(src_x[COORD_W-1:0], src_y[COORD_W-1:0])];
  endfunction

`ifdef CENTER_EN
  logic [COORD_W-1:0]        col_q, col_d;
  logic [COORD_W-1:0]        min_x, max_x, min_y, max_y;
  logic                      bbox_empty;
  logic signed [SRC_W-1:0]   sum_x, sum_y;
  logic signed [SHIFT_W-1:0] calc_sx, calc_sy;

  bbox_scanner u_bbox (
    .clk     (iBusClk),
    .rst_n   (iRstN),
    .clear_i (start_go),
    .step_i  (state_q == SCAN),
    .col_i   (snap_q[{col_q, 5'd0} +: IMG_DIM]),
    .idx_i   (col_q),
    .min_x_o (min_x),
    .max_x_o (max_x),
    .min_y_o (min_y),
    .max_y_o (max_y),
    .empty_o (bbox_empty)
  );

  // Centre offset: floor((31 - min - max) / 2), zero for a blank canvas.
  always_comb begin
    sum_x   = 7'sd31 - $signed({2'b00, min_x}) - $signed({2'b00, max_x});
    sum_y   = 7'sd31 - $signed({2'b00, min_y}) - $signed({2'b00, max_y});
    calc_sx = bbox_empty ? '0 : SHIFT_W'(sum_x >>> 1);
    calc_sy = bbox_empty ? '0 : SHIFT_W'(sum_y >>> 1);
  end
`endif

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    beat_d  = beat_q;
    pix_d   = pix_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    sx_d    = sx_q;
    sy_d    = sy_q;
`ifdef CENTER_EN
    col_d   = col_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_go) begin
          snap_d = iImage;
          beat_d = '0;
          last_d = 1'b0;
          sx_d   = '0;
          sy_d   = '0;
`ifdef CENTER_EN
          col_d   = '0;
          state_d = SCAN;
`else
          state_d = STREAM;
          valid_d = 1'b1;
          pix_d   = pix_bit(iImage, '0, '0, '0) ? PIX_ONE : '0;
`endif
        end
      end
`ifdef CENTER_EN
      SCAN: begin
        col_d = 5'(col_q + 5'd1);
        if (col_q == 5'd31) state_d = CALC;
      end
      CALC: begin
        sx_d    = calc_sx;
        sy_d    = calc_sy;
        state_d = STREAM;
        valid_d = 1'b1;
        pix_d   = pix_bit(snap_q, '0, calc_sx, calc_sy) ? PIX_ONE : '0;
      end
`endif
      STREAM: begin
        if (valid_q && m_if.iReady) begin
          if (beat_q == 10'd1023) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            pix_d   = '0;
            done_d  = 1'b1;
          end else begin
            beat_d = 10'(beat_q + 10'd1);
            last_d = (beat_q == 10'd1022);
            pix_d  = pix_bit(snap_q, 10'(beat_q + 10'd1), sx_q, sy_q) ? PIX_ONE : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iBusClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      snap_q  <= '0;
      beat_q  <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
`ifdef CENTER_EN
      col_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      beat_q  <= beat_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
`ifdef CENTER_EN
      col_q   <= col_d;
`endif
    end
  end

  assign m_if.oPixel = pix_q;
  assign m_if.oValid = valid_q;
  assign m_if.oLast  = last_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oShiftX     = sx_q;
  assign oShiftY     = sy_q;

endmodule

// File: tb/tb_image_streamer.sv
// Scoreboard bench for image_streamer; expectations follow CENTER_EN when defined.
module tb_image_streamer;
  import dnn_input_pkg::*;

  localparam int unsigned PW  = 8;
  localparam logic [7:0]  ONE = 8'd127;
`ifdef CENTER_EN
  localparam int EXP_LAT = 34;
`else
  localparam int EXP_LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1023:0]     image = '0;
  logic              done, busy;
  logic signed [5:0] shx, shy;

  image_streamer_if #(.PIX_W(PW)) bus ();

  image_streamer #(.PIX_W(PW), .PIX_ONE(ONE)) dut (
    .iBusClk (clk),
    .iRstN   (rst_n),
    .iStart  (start),
    .iImage  (image),
    .m_if    (bus),
    .oBusy   (busy),
    .oDone   (done),
    .oShiftX (shx),
    .oShiftY (shy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] q[$];
  int accepted, ones, first_one, last_one;
  bit pend_done, held_v;
  logic [7:0] held_pix;
  logic held_last;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fdiv2(input int s);
    return (s >= 0) ? s / 2 : -((1 - s) / 2);
  endfunction

  function automatic void model_shift(input logic [1023:0] img, output int sx, output int sy);
    int mnx, mxx, mny, mxy;
    mnx = 32; mxx = -1; mny = 32; mxy = -1;
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        if (img[x*32+y]) begin
          if (x < mnx) mnx = x;
          if (x > mxx) mxx = x;
          if (y < mny) mny = y;
          if (y > mxy) mxy = y;
        end
    sx = 0; sy = 0;
`ifdef CENTER_EN
    if (mxx >= 0) begin
      sx = fdiv2(31 - mnx - mxx);
      sy = fdiv2(31 - mny - mxy);
    end
`endif
  endfunction

  // Monitor: pops the scoreboard on every accepted beat, checks stall stability and done.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      held_v    = 1'b0;
      pend_done = 1'b0;
    end else begin
      if (pend_done) begin
        chk("done_after_last", int'(done), 1);
        chk("busy_low_in_done", int'(busy), 0);
        pend_done = 1'b0;
      end
      if (bus.oValid) begin
        if (held_v) begin
          chk("stall_pixel", int'(bus.oPixel), int'(held_pix));
          chk("stall_last", int'(bus.oLast), int'(held_last));
        end
        if (bus.iReady) begin
          if (q.size() == 0) begin
            chk("extra_beat", accepted, -1);
          end else begin
            e = q.pop_front();
            chk("pixel", int'(bus.oPixel), int'(e[7:0]));
            chk("last", int'(bus.oLast), int'(e[8]));
          end
          if (bus.oPixel == ONE) begin
            if (ones == 0) first_one = accepted;
            last_one = accepted;
            ones++;
          end
          if (bus.oLast) pend_done = 1'b1;
          accepted++;
          held_v = 1'b0;
        end else begin
          held_v    = 1'b1;
          held_pix  = bus.oPixel;
          held_last = bus.oLast;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input logic [1023:0] img, input bit rnd, input int poke_at,
                            input int rst_at, input bit start_in_done,
                            input int exp_sx, input int exp_sy);
    int sx, sy, cyc, lat;
    bit got_valid, poked, finished;
    model_shift(img, sx, sy);
    q.delete();
    for (int n = 0; n < 1024; n++) begin
      int ox, oy, srx, sry;
      logic [7:0] p;
      ox = n % 32; oy = n / 32; srx = ox - sx; sry = oy - sy;
      p = 8'd0;
      if (srx >= 0 && srx <= 31 && sry >= 0 && sry <= 31 && img[srx*32+sry]) p = ONE;
      q.push_back({(n == 1023), p});
    end
    accepted = 0; ones = 0; first_one = -1; last_one = -1;
    image = img;
    start = 1'b1;
    bus.iReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0; lat = 0; got_valid = 0; poked = 0; finished = 0;
    while (cyc < 5000) begin
      tick();
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk("busy_from_edge0", int'(busy), 1);
      if (!got_valid) begin
        lat++;
        if (bus.oValid) begin
          got_valid = 1;
          chk("first_valid_latency", lat, EXP_LAT);
          chk("shift_x", int'(shx), exp_sx);
          chk("shift_y", int'(shy), exp_sy);
        end
      end
      if (poke_at >= 0 && !poked && accepted >= poke_at) begin
        start = 1'b1;
        image = '0;
        poked = 1;
      end
      if (rst_at >= 0 && accepted >= rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pixel", int'(bus.oPixel), 0);
        chk("rst_valid", int'(bus.oValid), 0);
        chk("rst_last", int'(bus.oLast), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_shift_x", int'(shx), 0);
        chk("rst_shift_y", int'(shy), 0);
        q.delete();
        tick();
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        finished = 1;
        break;
      end
      bus.iReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("stream_completed", int'(finished), 1);
    chk("beats_accepted", accepted, 1024);
    chk("scoreboard_drained", q.size(), 0);
    if (start_in_done) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_in_done_ignored", int'(busy), 0);
      chk("no_valid_after_done", int'(bus.oValid), 0);
    end
    tick(); tick(); tick();
    chk("idle_after_stream", int'(busy), 0);
  endtask

  initial begin
    logic [1023:0] img;
    bus.iReady = 1'b0;
    #1;
    chk("reset_pixel", int'(bus.oPixel), 0);
    chk("reset_valid", int'(bus.oValid), 0);
    chk("reset_last", int'(bus.oLast), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_shift_x", int'(shx), 0);
    #20 rst_n = 1'b1;
    tick();

    // Single bit at x=3,y=5; start held during the done cycle.
    img = '0; img[101] = 1'b1;
`ifdef CENTER_EN
    run_stream(img, 0, -1, -1, 1, 12, 10);
    chk("single_bit_beat", last_one, 495);
`else
    run_stream(img, 0, -1, -1, 1, 0, 0);
    chk("single_bit_beat", last_one, 163);
`endif
    chk("single_bit_count", ones, 1);

    // Random image with random backpressure.
    for (int w = 0; w < 32; w++) img[w*32 +: 32] = $urandom;
    begin
      int sx, sy;
      model_shift(img, sx, sy);
      run_stream(img, 1, -1, -1, 0, sx, sy);
    end

    // 4x4 block in the corner.
    img = '0;
    for (int x = 0; x < 4; x++) for (int y = 0; y < 4; y++) img[x*32+y] = 1'b1;
`ifdef CENTER_EN
    run_stream(img, 0, -1, -1, 0, 14, 14);
    chk("block_first_beat", first_one, 14*32+14);
    chk("block_last_beat", last_one, 17*32+17);
`else
    run_stream(img, 0, -1, -1, 0, 0, 0);
    chk("block_first_beat", first_one, 0);
    chk("block_last_beat", last_one, 3*32+3);
`endif
    chk("block_count", ones, 16);

    // Empty canvas.
    run_stream('0, 0, -1, -1, 0, 0, 0);
    chk("empty_count", ones, 0);

    // Start pulse and canvas clear mid-stream must not disturb the frame.
    img = '0; img[7*32+9] = 1'b1; img[20*32+25] = 1'b1;
    begin
      int sx, sy;
      model_shift(img, sx, sy);
      run_stream(img, 1, 300, -1, 0, sx, sy);
    end
    chk("poke_count", ones, 2);

    // Reset at beat 500, then a fresh stream from beat 0.
    img = '1;
    begin
      int sx, sy;
      model_shift(img, sx, sy);
      run_stream(img, 0, -1, 500, 0, sx, sy);
    end
    tick();
    img = '0; img[101] = 1'b1;
`ifdef CENTER_EN
    run_stream(img, 0, -1, -1, 0, 12, 10);
    chk("after_reset_beat", last_one, 495);
`else
    run_stream(img, 0, -1, -1, 0, 0, 0);
    chk("after_reset_beat", last_one, 163);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
